non_restoring_divider: RTL and testbench

NON_RESTORING_DIVIDER -- requirements
Module: non_restoring_divider

---
 rtl/non_restoring_divider_pkg.sv | 27 ++
 rtl/non_restoring_divider_addsub.sv | 29 ++
 rtl/non_restoring_divider.sv | 197 +++++++++++++++++++
 tb/tb_non_restoring_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/non_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : non_restoring_divider_pkg
//  Description : Shared definitions for the non-restoring divider: default
//                operand width, FSM state encoding and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package non_restoring_divider_pkg;

    // Default operand width in bits.
    localparam int unsigned DEFAULT_N = 4;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2
    } state_t;

    // The iteration counter must hold the value n itself, so it needs
    // ceil(log2(n+1)) bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage : non_restoring_divider_pkg
`default_nettype wire

// File: rtl/non_restoring_divider_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : nrd_addsub
//  Description : W-bit wrap-around adder/subtractor. i_sub=1 gives
//                i_a - i_b, i_sub=0 gives i_a + i_b. A single carry-chain is
//                used: subtraction is a + ~b + 1.
//  Ports       : i_a, i_b  W-bit operands
//                i_sub     operation select (1 = subtract)
//                o_sum     W-bit result (carry out discarded)
//  Revision    : 1.0  initial release
// ============================================================================
module nrd_addsub #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_b_inv;
    logic [W-1:0] w_cin;

    assign w_b_inv = i_b ^ {W{i_sub}};
    assign w_cin   = {{(W-1){1'b0}}, i_sub};
    assign o_sum   = i_a + w_b_inv + w_cin;

endmodule : nrd_addsub
`default_nettype wire

// File: rtl/non_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : non_restoring_divider
//  Description : Sequential unsigned N-bit divider using the non-restoring
//                algorithm. One quotient bit per ITER cycle, followed by a
//                single CORR cycle that fixes up a negative remainder.
//  Ports       : clk    clock, rising edge
//                rst    synchronous active-high reset
//                start  request a division (sampled in IDLE only)
//                X, Y   unsigned dividend / divisor, sampled on accept
//                Q      N-bit quotient (registered)
//                R      N+1-bit remainder (registered, MSB 0 when valid)
//                busy   operation in progress
//                done   one-cycle pulse when Q/R/dbz are updated
//                dbz    divisor was zero; valid with done
//  Revision    : 1.0  initial release
// ============================================================================
module non_restoring_divider
    import non_restoring_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    output logic [N-1:0] Q,
    output logic [N:0]   R,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int c_AW    = N + 1;
    localparam int c_CNT_W = cnt_width(N);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;

    logic [c_AW-1:0]     r_a;      // partial remainder, two's complement
    logic [N-1:0]        r_qreg;   // dividend shifting out / quotient in
    logic [N-1:0]        r_y;      // latched divisor
    logic [c_CNT_W-1:0]  r_cnt;    // remaining ITER cycles

    logic [N-1:0]        r_q;
    logic [c_AW-1:0]     r_r;
    logic                r_busy;
    logic                r_done;
    logic                r_dbz;

    // FSM decode
    logic                w_accept;
    logic                w_iter;
    logic                w_corr;

    // Datapath wires
    logic [c_AW-1:0]     w_y_ext;
    logic [c_AW-1:0]     w_a_shift;
    logic [c_AW-1:0]     w_op_a;
    logic                w_op_sub;
    logic [c_AW-1:0]     w_sum;
    logic [c_AW-1:0]     w_a_corr;
    logic [N-1:0]        w_q_next;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iter      = 1'b0;
        w_corr      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ITER;
                end
            end
            ITER: begin
                w_iter = 1'b1;
                // Counter still holds the count for this cycle; value 1
                // means this is the last quotient bit.
                if (r_cnt == c_CNT_W'(1)) begin
                    w_state_nxt = CORR;
                end
            end
            CORR: begin
                w_corr      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared add/subtract
    //   ITER: operand is {A,Qreg} shifted left; subtract when A was >= 0.
    //   CORR: operand is A; only ever an add (result used only if A < 0).
    // ------------------------------------------------------------------------
    assign w_y_ext   = {1'b0, r_y};
    assign w_a_shift = {r_a[c_AW-2:0], r_qreg[N-1]};
    assign w_op_a    = w_corr ? r_a  : w_a_shift;
    assign w_op_sub  = w_corr ? 1'b0 : ~r_a[c_AW-1];

    nrd_addsub #(
        .W (c_AW)
    ) u_addsub (
        .i_a   (w_op_a),
        .i_b   (w_y_ext),
        .i_sub (w_op_sub),
        .o_sum (w_sum)
    );

    assign w_a_corr = r_a[c_AW-1] ? w_sum : r_a;

    // Quotient register shifted left with the new bit (sign of the new A,
    // inverted) entering at bit 0. Written as a loop so N=1 is legal.
    always_comb begin
        w_q_next    = '0;
        w_q_next[0] = ~w_sum[c_AW-1];
        for (int i = 1; i < N; i++) begin
            w_q_next[i] = r_qreg[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_qreg <= '0;
            r_y    <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_a    <= '0;
                r_qreg <= X;
                r_y    <= Y;
                r_cnt  <= c_CNT_W'(N);
                r_busy <= 1'b1;
                r_dbz  <= 1'b0;
            end

            if (w_iter) begin
                r_a    <= w_sum;
                r_qreg <= w_q_next;
                r_cnt  <= r_cnt - c_CNT_W'(1);
            end

            // With Y=0 every step subtracts zero, A never goes negative and
            // the result falls out as Q=all ones, R={0,X} without special
            // casing; only the flag needs computing.
            if (w_corr) begin
                r_a    <= w_a_corr;
                r_q    <= r_qreg;
                r_r    <= w_a_corr;
                r_done <= 1'b1;
                r_busy <= 1'b0;
                r_dbz  <= (r_y == '0);
            end
        end
    end

    assign Q    = r_q;
    assign R    = r_r;
    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;

endmodule : non_restoring_divider
`default_nettype wire

// File: tb/tb_non_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_non_restoring_divider
//  Description : Self-checking bench for non_restoring_divider (N=4).
//                Reference results come from plain integer / and %.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_non_restoring_divider;

    localparam int N   = 4;
    localparam int LAT = N + 1;   // clock edges from accept edge to done

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] Q;
    logic [N:0]   R;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks = 0;
    int passes = 0;

    non_restoring_divider #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Helpers (stimulus / model only)
    // ------------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ref_div(input int x, input int y,
                           output int q, output int r, output bit z);
        if (y == 0) begin
            q = (1 << N) - 1;
            r = x;
            z = 1'b1;
        end else begin
            q = x / y;
            r = x % y;
            z = 1'b0;
        end
    endtask

    task automatic launch(input int x, input int y);
        X     = N'(x);
        Y     = N'(y);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done. With noise set, start/X/Y are toggled while busy.
    task automatic wait_done(input bit noise, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (noise && busy) begin
                start = 1'($urandom_range(0, 1));
                X     = N'($urandom);
                Y     = N'($urandom);
            end
            tick();
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (noise) start = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        tick(); tick();
        checks++; if (Q    !== 4'd0) $display("FAIL reset_q got %0d exp 0", Q);    else passes++;
        checks++; if (R    !== 5'd0) $display("FAIL reset_r got %0d exp 0", R);    else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passes++;
        checks++; if (dbz  !== 1'b0) $display("FAIL reset_dbz got %b exp 0", dbz);  else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        int tx[9]  = '{6, 12, 13, 14, 5, 9, 0, 7, 15};
        int ty[9]  = '{2, 3, 12, 9, 10, 12, 0, 0, 1};
        int tq[9]  = '{3, 4, 1, 1, 0, 0, 15, 15, 15};
        int tr[9]  = '{0, 0, 1, 5, 5, 9, 0, 7, 0};
        bit tz[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
        int lat;
        bit ok;
        for (int i = 0; i < 9; i++) begin
            launch(tx[i], ty[i]);
            checks++; if (busy !== 1'b1) $display("FAIL dir_busy[%0d] got %b exp 1", i, busy); else passes++;
            // Operands change right after acceptance; result must not care.
            X = N'(~tx[i]);
            Y = N'(ty[i] + 5);
            wait_done(1'b0, lat, ok);
            checks++; if (!ok)        $display("FAIL dir_timeout[%0d] got no done exp done", i); else passes++;
            checks++; if (lat !== LAT) $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, LAT); else passes++;
            checks++; if (Q   !== N'(tq[i]))   $display("FAIL dir_q[%0d] got %0d exp %0d", i, Q, tq[i]); else passes++;
            checks++; if (R   !== (N+1)'(tr[i])) $display("FAIL dir_r[%0d] got %0d exp %0d", i, R, tr[i]); else passes++;
            checks++; if (dbz !== tz[i])       $display("FAIL dir_dbz[%0d] got %b exp %b", i, dbz, tz[i]); else passes++;
            checks++; if (busy !== 1'b0)       $display("FAIL dir_busy_done[%0d] got %b exp 0", i, busy); else passes++;
            tick(); tick();
            checks++; if (done !== 1'b0) $display("FAIL dir_pulse[%0d] got %b exp 0", i, done); else passes++;
            checks++; if (Q !== N'(tq[i]) || R !== (N+1)'(tr[i]) || dbz !== tz[i])
                $display("FAIL dir_hold[%0d] got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b",
                         i, Q, R, dbz, tq[i], tr[i], tz[i]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit ok;
        bit seen;
        launch(13, 3);
        tick(); tick();            // now in third ITER cycle
        rst   = 1'b1;
        start = 1'b1;              // reset must win over start
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checks++; if (Q    !== 4'd0) $display("FAIL rmid_q got %0d exp 0", Q);     else passes++;
        checks++; if (R    !== 5'd0) $display("FAIL rmid_r got %0d exp 0", R);     else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rmid_done got %b exp 0", done); else passes++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) $display("FAIL rmid_no_done got activity=%b exp 0", seen); else passes++;
        launch(11, 4);
        wait_done(1'b0, lat, ok);
        checks++; if (!ok || lat !== LAT) $display("FAIL rmid_restart_lat got ok=%b lat=%0d exp lat=%0d", ok, lat, LAT); else passes++;
        checks++; if (Q !== 4'd2 || R !== 5'd3 || dbz !== 1'b0)
            $display("FAIL rmid_restart got q=%0d r=%0d z=%b exp q=2 r=3 z=0", Q, R, dbz);
        else passes++;
        tick();
    endtask

    task automatic test_back_to_back;
        int lat, eq, er;
        bit ok, ez;
        X = '0; Y = '0;
        start = 1'b1;
        tick();                                 // accepts pair 0
        for (int p = 0; p < 256; p++) begin
            X = N'((p + 1) >> 4);
            Y = N'((p + 1) & 15);
            wait_done(1'b0, lat, ok);
            ref_div(p >> 4, p & 15, eq, er, ez);
            checks++; if (!ok || lat !== LAT)
                $display("FAIL b2b_lat[%0d] got ok=%b lat=%0d exp %0d", p, ok, lat, LAT);
            else passes++;
            checks++; if (Q !== N'(eq) || R !== (N+1)'(er) || dbz !== ez)
                $display("FAIL b2b_res[x=%0d y=%0d] got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b",
                         p >> 4, p & 15, Q, R, dbz, eq, er, ez);
            else passes++;
            if (p == 255) start = 1'b0;
            tick();
            checks++; if (busy !== (p != 255))
                $display("FAIL b2b_accept[%0d] got busy=%b exp %b", p, busy, (p != 255));
            else passes++;
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_random;
        int x, y, lat, eq, er;
        bit ok, ez;
        for (int n = 0; n < 40; n++) begin
            x = int'($urandom_range(0, 15));
            y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            launch(x, y);
            wait_done(1'b1, lat, ok);
            ref_div(x, y, eq, er, ez);
            checks++; if (!ok || lat !== LAT)
                $display("FAIL rnd_lat[%0d] got ok=%b lat=%0d exp %0d", n, ok, lat, LAT);
            else passes++;
            checks++; if (Q !== N'(eq) || R !== (N+1)'(er) || dbz !== ez)
                $display("FAIL rnd_res[x=%0d y=%0d] got q=%0d r=%0d z=%b exp q=%0d r=%0d z=%b",
                         x, y, Q, R, dbz, eq, er, ez);
            else passes++;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_non_restoring_divider
`default_nettype wire
